// File: rtl/reg_file_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_fetch
//  Description : Operand-fetch stage feeding the ALU. Holds the general-purpose
//                register file with two combinational read ports (write-first
//                bypass) and one writeback port, selects B from a register or
//                a constant, and registers A, B, S_ALU and CIN into a single
//                valid/ready pipeline slot.
//  Options     : define REG_ZERO_HARDWIRED_EN to make register 0 a constant
//                zero (writes to it ignored, no bypass for address 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_fetch #(
    parameter int WIDTH     = 16,
    parameter int REG_COUNT = 8,
    parameter int ADDR_W    = 3
) (
    input  logic              CLK,
    input  logic              RST,
    // Writeback port
    input  logic              WR_EN,
    input  logic [ADDR_W-1:0] DA,
    input  logic [WIDTH-1:0]  D_IN,
    // Fetch request
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [ADDR_W-1:0] AA,
    input  logic [ADDR_W-1:0] BA,
    input  logic              MB,
    input  logic [WIDTH-1:0]  CONST_IN,
    input  logic [2:0]        S_ALU_IN,
    input  logic              CIN_IN,
    // Operand slot towards the ALU
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [WIDTH-1:0]  A_OUT,
    output logic [WIDTH-1:0]  B_OUT,
    output logic [2:0]        S_ALU_OUT,
    output logic              CIN_OUT
);

`ifdef REG_ZERO_HARDWIRED_EN
    localparam bit c_zero_hardwired = 1'b1;
`else
    localparam bit c_zero_hardwired = 1'b0;
`endif

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_state_t;

    // ------------------------------------------------------------------------
    // Register file storage
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0]     w_regs [REG_COUNT];
    logic [REG_COUNT-1:0] w_wr_sel;
    logic                 w_wr_any;

    // One storage word per implemented register. The per-register write select
    // only exists for addresses below REG_COUNT, so an out-of-range DA selects
    // nothing and is silently dropped.
    for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_reg
        if (c_zero_hardwired && (gi == 0)) begin : g_zero
            assign w_wr_sel[gi] = 1'b0;
            assign w_regs[gi]   = '0;
        end else begin : g_store
            logic [WIDTH-1:0] r_q;

            assign w_wr_sel[gi] = WR_EN && (DA == ADDR_W'(gi));

            // Writeback into this register; reset clears it and wins over WR_EN.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_q <= '0;
                end else if (w_wr_sel[gi]) begin
                    r_q <= D_IN;
                end
            end

            assign w_regs[gi] = r_q;
        end
    end

    // A write that actually lands in a register this cycle; this is also the
    // exact condition under which the bypass is allowed to forward D_IN.
    assign w_wr_any = |w_wr_sel;

    // ------------------------------------------------------------------------
    // Read ports with write-first bypass
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_raw_a;
    logic [WIDTH-1:0] w_raw_b;
    logic [WIDTH-1:0] w_op_b;

    // Port A: addresses with no implemented register read as zero.
    always_comb begin
        w_raw_a = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (AA == ADDR_W'(i)) begin
                w_raw_a = w_regs[i];
            end
        end
        if (w_wr_any && (DA == AA)) begin
            w_raw_a = D_IN;
        end
    end

    // Port B: same rules as port A, addressed by BA.
    always_comb begin
        w_raw_b = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (BA == ADDR_W'(i)) begin
                w_raw_b = w_regs[i];
            end
        end
        if (w_wr_any && (DA == BA)) begin
            w_raw_b = D_IN;
        end
    end

    // MB mux: constant operand replaces the register value entirely.
    assign w_op_b = MB ? CONST_IN : w_raw_b;

    // ------------------------------------------------------------------------
    // Single-entry pipeline slot
    // ------------------------------------------------------------------------
    slot_state_t r_state;
    slot_state_t w_next_state;
    logic        w_capture;

    logic [WIDTH-1:0] r_a_out;
    logic [WIDTH-1:0] r_b_out;
    logic [2:0]       r_s_alu_out;
    logic             r_cin_out;

    // Slot occupancy register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and capture decision. Ready depends only on the slot state
    // and the consumer, never on IN_VALID, so no combinational loop can form
    // through an upstream that waits for ready.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (IN_VALID) begin
                    w_capture    = 1'b1;
                    w_next_state = S_FULL;
                end
            end
            S_FULL: begin
                if (OUT_READY) begin
                    if (IN_VALID) begin
                        w_capture    = 1'b1;
                        w_next_state = S_FULL;
                    end else begin
                        w_next_state = S_EMPTY;
                    end
                end
            end
            default: begin
                w_next_state = S_EMPTY;
            end
        endcase
    end

    // Operand snapshot: values are frozen at capture, so later writebacks to
    // the source registers cannot disturb a stalled slot.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_a_out     <= '0;
            r_b_out     <= '0;
            r_s_alu_out <= '0;
            r_cin_out   <= 1'b0;
        end else if (w_capture) begin
            r_a_out     <= w_raw_a;
            r_b_out     <= w_op_b;
            r_s_alu_out <= S_ALU_IN;
            r_cin_out   <= CIN_IN;
        end
    end

    assign IN_READY  = (r_state == S_EMPTY) || OUT_READY;
    assign OUT_VALID = (r_state == S_FULL);
    assign A_OUT     = r_a_out;
    assign B_OUT     = r_b_out;
    assign S_ALU_OUT = r_s_alu_out;
    assign CIN_OUT   = r_cin_out;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file_fetch
//  Description : Directed, table-driven self-checking bench for reg_file_fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_fetch;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [2:0]  da;
    logic [15:0] d_in;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  aa;
    logic [2:0]  ba;
    logic        mb;
    logic [15:0] const_in;
    logic [2:0]  s_alu_in;
    logic        cin_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] a_out;
    logic [15:0] b_out;
    logic [2:0]  s_alu_out;
    logic        cin_out;

    reg_file_fetch #(
        .WIDTH     (16),
        .REG_COUNT (8),
        .ADDR_W    (3)
    ) u_dut (
        .CLK       (clk),
        .RST       (rst),
        .WR_EN     (wr_en),
        .DA        (da),
        .D_IN      (d_in),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .AA        (aa),
        .BA        (ba),
        .MB        (mb),
        .CONST_IN  (const_in),
        .S_ALU_IN  (s_alu_in),
        .CIN_IN    (cin_in),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .A_OUT     (a_out),
        .B_OUT     (b_out),
        .S_ALU_OUT (s_alu_out),
        .CIN_OUT   (cin_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected register-0 behaviour for the two builds.
`ifdef REG_ZERO_HARDWIRED_EN
    localparam logic [15:0] R0_AFTER_WR = 16'h0000;
    localparam logic [15:0] R0_BYPASS   = 16'h0000;
`else
    localparam logic [15:0] R0_AFTER_WR = 16'hFFFF;
    localparam logic [15:0] R0_BYPASS   = 16'h1111;
`endif

    typedef struct packed {
        logic        rst;
        logic        wr;
        logic [2:0]  da;
        logic [15:0] din;
        logic        iv;
        logic [2:0]  aa;
        logic [2:0]  ba;
        logic        mb;
        logic [15:0] k;
        logic [2:0]  s;
        logic        cin;
        logic        ordy;
        logic        eir;
        logic        ev;
        logic [15:0] ea;
        logic [15:0] eb;
        logic [2:0]  es;
        logic        ecin;
    } vec_t;

    vec_t vq[$];
    int   n_pass;
    int   n_total;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one vector at the falling edge, check ready before the rising
    // edge, then check the registered outputs just after it.
    task automatic apply(input int idx, input vec_t v);
        @(negedge clk);
        rst       = v.rst;
        wr_en     = v.wr;
        da        = v.da;
        d_in      = v.din;
        in_valid  = v.iv;
        aa        = v.aa;
        ba        = v.ba;
        mb        = v.mb;
        const_in  = v.k;
        s_alu_in  = v.s;
        cin_in    = v.cin;
        out_ready = v.ordy;
        #1;
        check($sformatf("v%0d in_ready", idx), {31'd0, in_ready}, {31'd0, v.eir});
        @(posedge clk);
        #1;
        check($sformatf("v%0d out_valid", idx), {31'd0, out_valid}, {31'd0, v.ev});
        check($sformatf("v%0d a_out", idx),     {16'd0, a_out},     {16'd0, v.ea});
        check($sformatf("v%0d b_out", idx),     {16'd0, b_out},     {16'd0, v.eb});
        check($sformatf("v%0d s_alu_out", idx), {29'd0, s_alu_out}, {29'd0, v.es});
        check($sformatf("v%0d cin_out", idx),   {31'd0, cin_out},   {31'd0, v.ecin});
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b1;
        wr_en     = 1'b0;
        da        = '0;
        d_in      = '0;
        in_valid  = 1'b0;
        aa        = '0;
        ba        = '0;
        mb        = 1'b0;
        const_in  = '0;
        s_alu_in  = '0;
        cin_in    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);

        //           rst  wr  da  din       iv  aa  ba  mb  k         s  cin ordy  eir ev  ea        eb        es ecin
        vq.push_back({1'b1,1'b0,3'd0,16'h0000,1'b0,3'd0,3'd0,1'b0,16'h0000,3'd0,1'b0,1'b0, 1'b1,1'b0,16'h0000,16'h0000,3'd0,1'b0}); // 0 reset state
        vq.push_back({1'b0,1'b0,3'd0,16'h0000,1'b1,3'd3,3'd5,1'b0,16'h0000,3'd0,1'b0,1'b1, 1'b1,1'b1,16'h0000,16'h0000,3'd0,1'b0}); // 1 fetch after reset
        vq.push_back({1'b0,1'b1,3'd2,16'h1234,1'b0,3'd0,3'd0,1'b0,16'h0000,3'd0,1'b0,1'b1, 1'b1,1'b0,16'h0000,16'h0000,3'd0,1'b0}); // 2 write R2, slot drains
        vq.push_back({1'b0,1'b0,3'd0,16'h0000,1'b1,3'd2,3'd2,1'b1,16'h00FF,3'd1,1'b1,1'b1, 1'b1,1'b1,16'h1234,16'h00FF,3'd1,1'b1}); // 3 read R2, const B
        vq.push_back({1'b0,1'b1,3'd4,16'hBEEF,1'b1,3'd4,3'd2,1'b0,16'h0000,3'd2,1'b0,1'b1, 1'b1,1'b1,16'hBEEF,16'h1234,3'd2,1'b0}); // 4 bypass on A
        vq.push_back({1'b0,1'b1,3'd1,16'h0011,1'b0,3'd0,3'd0,1'b0,16'h0000,3'd0,1'b0,1'b1, 1'b1,1'b0,16'hBEEF,16'h1234,3'd2,1'b0}); // 5 write R1, hold outputs
        vq.push_back({1'b0,1'b0,3'd0,16'h0000,1'b1,3'd1,3'd4,1'b0,16'h0000,3'd5,1'b1,1'b1, 1'b1,1'b1,16'h0011,16'hBEEF,3'd5,1'b1}); // 6 fetch R1
        vq.push_back({1'b0,1'b1,3'd1,16'h9999,1'b1,3'd3,3'd3,1'b0,16'h0000,3'd6,1'b0,1'b0, 1'b0,1'b1,16'h0011,16'hBEEF,3'd5,1'b1}); // 7 stall + write R1
        vq.push_back({1'b0,1'b0,3'd0,16'h0000,1'b1,3'd1,3'd1,1'b0,16'h0000,3'd6,1'b0,1'b0, 1'b0,1'b1,16'h0011,16'hBEEF,3'd5,1'b1}); // 8 stall
        vq.push_back({1'b0,1'b0,3'd0,16'h0000,1'b0,3'd0,3'd0,1'b0,16'h0000,3'd0,1'b0,1'b0, 1'b0,1'b1,16'h0011,16'hBEEF,3'd5,1'b1}); // 9 stall
        vq.push_back({1'b0,1'b0,3'd0,16'h0000,1'b0,3'd0,3'd0,1'b0,16'h0000,3'd0,1'b0,1'b1, 1'b1,1'b0,16'h0011,16'hBEEF,3'd5,1'b1}); // 10 release
        vq.push_back({1'b0,1'b0,3'd0,16'h0000,1'b1,3'd1,3'd1,1'b0,16'h0000,3'd7,1'b0,1'b1, 1'b1,1'b1,16'h9999,16'h9999,3'd7,1'b0}); // 11 refetch R1
        vq.push_back({1'b0,1'b1,3'd3,16'h3333,1'b0,3'd0,3'd0,1'b0,16'h0000,3'd0,1'b0,1'b1, 1'b1,1'b0,16'h9999,16'h9999,3'd7,1'b0}); // 12 write R3
        vq.push_back({1'b0,1'b0,3'd0,16'h0000,1'b1,3'd0,3'd0,1'b0,16'h0000,3'd0,1'b0,1'b1, 1'b1,1'b1,16'h0000,16'h0000,3'd0,1'b0}); // 13 stream R0
        vq.push_back({1'b0,1'b0,3'd0,16'h0000,1'b1,3'd1,3'd1,1'b0,16'h0000,3'd1,1'b1,1'b1, 1'b1,1'b1,16'h9999,16'h9999,3'd1,1'b1}); // 14 stream R1
        vq.push_back({1'b0,1'b0,3'd0,16'h0000,1'b1,3'd2,3'd2,1'b0,16'h0000,3'd2,1'b0,1'b1, 1'b1,1'b1,16'h1234,16'h1234,3'd2,1'b0}); // 15 stream R2
        vq.push_back({1'b0,1'b0,3'd0,16'h0000,1'b1,3'd3,3'd3,1'b0,16'h0000,3'd3,1'b1,1'b1, 1'b1,1'b1,16'h3333,16'h3333,3'd3,1'b1}); // 16 stream R3
        vq.push_back({1'b0,1'b0,3'd0,16'h0000,1'b1,3'd4,3'd0,1'b1,16'h5A5A,3'd4,1'b0,1'b0, 1'b0,1'b1,16'h3333,16'h3333,3'd3,1'b1}); // 17 full, blocked
        vq.push_back({1'b1,1'b1,3'd5,16'hFFFF,1'b1,3'd5,3'd5,1'b0,16'h0000,3'd1,1'b1,1'b1, 1'b1,1'b0,16'h0000,16'h0000,3'd0,1'b0}); // 18 reset mid-flight
        vq.push_back({1'b0,1'b0,3'd0,16'h0000,1'b1,3'd5,3'd4,1'b0,16'h0000,3'd6,1'b1,1'b1, 1'b1,1'b1,16'h0000,16'h0000,3'd6,1'b1}); // 19 regs cleared
        vq.push_back({1'b0,1'b1,3'd0,16'hFFFF,1'b0,3'd0,3'd0,1'b0,16'h0000,3'd0,1'b0,1'b1, 1'b1,1'b0,16'h0000,16'h0000,3'd6,1'b1}); // 20 write R0
        vq.push_back({1'b0,1'b0,3'd0,16'h0000,1'b1,3'd0,3'd0,1'b0,16'h0000,3'd1,1'b0,1'b1, 1'b1,1'b1,R0_AFTER_WR,R0_AFTER_WR,3'd1,1'b0}); // 21 read R0
        vq.push_back({1'b0,1'b1,3'd0,16'h1111,1'b1,3'd0,3'd0,1'b0,16'h0000,3'd2,1'b1,1'b1, 1'b1,1'b1,R0_BYPASS,R0_BYPASS,3'd2,1'b1});   // 22 R0 bypass

        for (int i = 0; i < vq.size(); i++) begin
            apply(i, vq[i]);
        end

        // Ready must follow OUT_READY combinationally while the slot is full.
        @(negedge clk);
        wr_en     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("seq ready_low_when_full", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        #1;
        check("seq ready_follows_out_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("seq held_valid", {31'd0, out_valid}, 32'd1);
        check("seq held_a", {16'd0, a_out}, {16'd0, R0_BYPASS});

        // Release the slot and wait, bounded, for it to drain.
        @(negedge clk);
        out_ready = 1'b1;
        begin
            int cycles;
            cycles = 0;
            while (out_valid === 1'b1 && cycles < 5) begin
                @(posedge clk);
                #1;
                cycles++;
            end
            check("seq drain_valid", {31'd0, out_valid}, 32'd0);
            check("seq drain_cycles", cycles, 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_file_fetch.md
Name: reg_file_fetch

Overview:
- Operand-fetch stage directly upstream of the ALU in the tiny-processor datapath.
- Holds the general-purpose register file (8 x WIDTH by default) with two read ports and one write port; the write port is driven by the writeback bus.
- Selects B from either a register or a constant (MB mux).
- Registers A, B, S_ALU and CIN into a single-entry valid/ready pipeline slot whose outputs drive the ALU's A, B, S_ALU and CIN.

Parameters:
- WIDTH, 16, data width of registers and operands.
- REG_COUNT, 8, number of implemented registers; legal range 2..2**ADDR_W.
- ADDR_W, 3, register address width.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-high reset.
- WR_EN  input  1  writeback enable.
- DA  input  ADDR_W  writeback destination register.
- D_IN  input  WIDTH  writeback data.
- IN_VALID  input  1  fetch request valid.
- IN_READY  output  1  fetch request accepted this cycle when high with IN_VALID.
- AA  input  ADDR_W  A-operand register address.
- BA  input  ADDR_W  B-operand register address.
- MB  input  1  0 = B from register BA, 1 = B from CONST_IN.
- CONST_IN  input  WIDTH  constant operand.
- S_ALU_IN  input  3  ALU function select, passed through.
- CIN_IN  input  1  ALU carry-in, passed through.
- OUT_VALID  output  1  pipeline slot holds a valid operand set.
- OUT_READY  input  1  ALU stage consumes the slot.
- A_OUT  output  WIDTH  registered A operand, to ALU A.
- B_OUT  output  WIDTH  registered B operand, to ALU B.
- S_ALU_OUT  output  3  registered, to ALU S_ALU.
- CIN_OUT  output  1  registered, to ALU CIN.

Behaviour:
Reset:
- On RST at a CLK edge: all registers become 0; OUT_VALID=0; A_OUT, B_OUT, S_ALU_OUT, CIN_OUT = 0.
- RST overrides WR_EN and any capture in the same cycle.
- An in-flight slot is discarded, with no completion.

Register write:
- At the CLK edge with WR_EN=1 and DA < REG_COUNT: reg[DA] <= D_IN.
- DA >= REG_COUNT: write ignored.

Read:
- Combinational, with write-first bypass.
- Raw A = (WR_EN && DA==AA && DA<REG_COUNT) ? D_IN : reg[AA]. Same rule for raw B using BA.
- An address >= REG_COUNT reads 0.
- Operand B = MB ? CONST_IN : raw B. The bypass is irrelevant when MB=1.

Slot FSM: two states, EMPTY (OUT_VALID=0) and FULL (OUT_VALID=1).
- IN_READY = ~OUT_VALID | OUT_READY (combinational; no combinational path from IN_VALID to IN_READY).
- Accept = IN_VALID & IN_READY.
- On accept: capture A, B, S_ALU_IN, CIN_IN into the outputs; next state FULL.
- EMPTY, no accept: stay EMPTY; outputs hold their last values.
- FULL, OUT_READY=1 and accept: stay FULL with new data (back-to-back, one fetch per cycle).
- FULL, OUT_READY=1, no accept: go EMPTY.
- FULL, OUT_READY=0: hold. Outputs are stable and snapshot semantics apply: later writes to the source registers do not change A_OUT or B_OUT.
- Latency: request accepted at edge n gives OUT_VALID=1 with data after edge n.
- A write and a fetch of the same register in the same cycle capture the new D_IN value, via the bypass.

Simultaneous events:
- Writeback is independent of the handshake. A write proceeds while the slot is stalled, and while IN_VALID is low.

Optional Feature:
- Macro: REG_ZERO_HARDWIRED_EN.
- Defined: register 0 always reads 0, writes to DA=0 are ignored, and there is no bypass for address 0.
- Undefined: register 0 is an ordinary register.

Test Plan:
- Reset value: after RST, fetch AA=3, BA=5, MB=0 -> after one edge OUT_VALID=1, A_OUT=0x0000, B_OUT=0x0000.
- Write then read: write R2=0x1234 (WR_EN=1, DA=2); next cycle fetch AA=2, BA=2, MB=1, CONST_IN=0x00FF, S_ALU_IN=3'b001, CIN_IN=1 -> A_OUT=0x1234, B_OUT=0x00FF, S_ALU_OUT=3'b001, CIN_OUT=1.
- Bypass: same cycle WR_EN=1, DA=4, D_IN=0xBEEF and fetch AA=4 -> A_OUT=0xBEEF.
- Stall and snapshot:
  - Setup: R1=0x0011; fetch AA=1; OUT_READY=0 for 3 cycles; during the stall write R1=0x9999.
  - Required response: A_OUT stays 0x0011; IN_READY=0 during the stall.
  - After OUT_READY=1: the slot is released, and a new fetch of R1 gives 0x9999.
- Throughput: IN_VALID=1 and OUT_READY=1 for 4 cycles with AA=0..3 -> 4 consecutive OUT_VALID cycles carrying reg[0..3] in order; IN_READY held 1.
- Reset mid-operation and R0 macro:
  - FULL slot, then assert RST -> OUT_VALID=0 and all outputs 0 the next cycle.
  - With REG_ZERO_HARDWIRED_EN defined: write R0=0xFFFF, then fetch AA=0 -> A_OUT=0x0000.
